reg_file_y86: RTL

- Y86-64 general-purpose register file; consumes the srcA/srcB/dstE/dstM register IDs produced by decode-stage selection logic.
- Two combinational read ports (decode stage) and two synchronous write ports (write-back: E from ALU, M from memory).
- 15 architectural registers (IDs 0x0-0xE); ID 0xF (NonReg) means "no register".
- Tracks per-register written-since-reset status and a retire counter for debug and bench visibility.

---
 rtl/reg_file_y86_pkg.sv | 16 +
 rtl/reg_file_y86_if.sv | 27 ++
 rtl/reg_file_y86_reg_wr_decode.sv | 40 ++++
 rtl/reg_file_y86.sv | 97 +++++++++
 4 files changed

// File: rtl/reg_file_y86_pkg.sv
// Shared constants and helpers for the Y86-64 register file.
package reg_file_y86_pkg;

   localparam int ADDR_WID      = 4;
   localparam int DATA_WID_DFLT = 64;

   localparam logic [ADDR_WID-1:0] NonReg_ = 4'hF;
   localparam logic [ADDR_WID-1:0] rsp_    = 4'h4;

   // True when id names an implemented register (not NonReg, below nreg).
   function automatic logic id_ok(input logic [ADDR_WID-1:0] id,
                                  input logic [ADDR_WID:0]   nreg);
      return (id != NonReg_) && ({1'b0, id} < nreg);
   endfunction

endpackage

// File: rtl/reg_file_y86_if.sv
// Decode-stage read bus and write-back bus of the register file.
interface reg_file_y86_if #(
   parameter int DATA_WID = 64
);
   import reg_file_y86_pkg::*;

   logic [ADDR_WID-1:0] srcA;
   logic [ADDR_WID-1:0] srcB;
   logic [DATA_WID-1:0] valA;
   logic [DATA_WID-1:0] valB;
   logic                wb_en;
   logic [ADDR_WID-1:0] dstE;
   logic [DATA_WID-1:0] valE;
   logic [ADDR_WID-1:0] dstM;
   logic [DATA_WID-1:0] valM;

   modport master (
      output srcA, srcB, wb_en, dstE, valE, dstM, valM,
      input  valA, valB
   );

   modport slave (
      input  srcA, srcB, wb_en, dstE, valE, dstM, valM,
      output valA, valB
   );

endinterface

// File: rtl/reg_file_y86_reg_wr_decode.sv
// Write-back decode: one-hot write enables for the E and M ports, number of
// distinct writes this cycle, and the same-destination conflict flag.
module reg_wr_decode
   import reg_file_y86_pkg::*;
#(
   parameter int NREG = 15
) (
   input  logic [ADDR_WID-1:0] dstE,
   input  logic [ADDR_WID-1:0] dstM,
   input  logic                wb_en,
   output logic [NREG-1:0]     we_e,
   output logic [NREG-1:0]     we_m,
   output logic [1:0]          wr_count,
   output logic                conflict_d
);

   localparam logic [ADDR_WID:0] NREG_W = (ADDR_WID+1)'(NREG);

   logic valid_e;
   logic valid_m;
   logic same;

   assign valid_e = wb_en && id_ok(dstE, NREG_W);
   assign valid_m = wb_en && id_ok(dstM, NREG_W);
   assign same    = valid_e && valid_m && (dstE == dstM);

   // M masks E on a shared destination so popq %rsp keeps the memory value.
   always_comb begin
      we_e = '0;
      we_m = '0;
      for (int i = 0; i < NREG; i++) begin
         we_m[i] = valid_m && (dstM == ADDR_WID'(i));
         we_e[i] = valid_e && (dstE == ADDR_WID'(i)) && !same;
      end
   end

   assign wr_count   = {1'b0, valid_e} + {1'b0, valid_m} - {1'b0, same};
   assign conflict_d = wb_en && (dstE == dstM) && (dstE != NonReg_);

endmodule

// File: rtl/reg_file_y86.sv
// Y86-64 register file: two combinational read ports, two write-back ports
// (E from ALU, M from memory), written-since-reset flags, retired-write count.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module reg_file_y86
   import reg_file_y86_pkg::*;
#(
   parameter int DATA_WID = 64,
   parameter int NREG     = 15,
   parameter int CNT_WID  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   reg_file_y86_if.slave      bus,
   output logic [NREG-1:0]    written,
   output logic [CNT_WID-1:0] wr_cnt,
   output logic               conflict
);

   localparam logic [ADDR_WID:0] NREG_W = (ADDR_WID+1)'(NREG);

   logic [DATA_WID-1:0] regs [NREG];
   logic [NREG-1:0]     we_e;
   logic [NREG-1:0]     we_m;
   logic [1:0]          wr_count;
   logic                conflict_d;
   logic [DATA_WID-1:0] val_a;
   logic [DATA_WID-1:0] val_b;

   reg_wr_decode #(
      .NREG (NREG)
   ) u_wr_decode (
      .dstE       (bus.dstE),
      .dstM       (bus.dstM),
      .wb_en      (bus.wb_en),
      .we_e       (we_e),
      .we_m       (we_m),
      .wr_count   (wr_count),
      .conflict_d (conflict_d)
   );

   // Register array update; M has priority when both ports hit one entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (we_m[i])      regs[i] <= bus.valM;
            else if (we_e[i]) regs[i] <= bus.valE;
         end
      end
   end

   // Status: written flags, wrapping write counter, one-cycle conflict pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         written  <= '0;
         wr_cnt   <= '0;
         conflict <= 1'b0;
      end else begin
         written  <= written | we_e | we_m;
         wr_cnt   <= wr_cnt + CNT_WID'(wr_count);
         conflict <= conflict_d;
      end
   end

   // Read port A: unimplemented IDs and NonReg read as zero.
   always_comb begin
      val_a = '0;
      if (id_ok(bus.srcA, NREG_W)) begin
`ifdef REGFILE_BYPASS_EN
         if (we_m[bus.srcA])      val_a = bus.valM;
         else if (we_e[bus.srcA]) val_a = bus.valE;
         else                     val_a = regs[bus.srcA];
`else
         val_a = regs[bus.srcA];
`endif
      end
   end

   // Read port B: same rules as port A.
   always_comb begin
      val_b = '0;
      if (id_ok(bus.srcB, NREG_W)) begin
`ifdef REGFILE_BYPASS_EN
         if (we_m[bus.srcB])      val_b = bus.valM;
         else if (we_e[bus.srcB]) val_b = bus.valE;
         else                     val_b = regs[bus.srcB];
`else
         val_b = regs[bus.srcB];
`endif
      end
   end

   assign bus.valA = val_a;
   assign bus.valB = val_b;

endmodule
